// File: rtl/sort_array_p.sv
// Insertion sorter: entries are placed in key order as they arrive, then the
// frame is drained from slot 0 with a valid/ready handshake.
//
// state | meaning
// LOAD  | accepting entries, each one inserted in sorted position on arrival
// DRAIN | presenting slot 0 and shifting the array up on every handshake
module sort_array_p #(
    parameter int DEPTH   = 32,
    parameter int KEY_W   = 24,
    parameter int TAG_W   = 5,
    parameter int DESCEND = 0,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int EW     = KEY_W + TAG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_W-1:0]    in_key,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [KEY_W-1:0]    out_key,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_last,
    output logic [CW-1:0]       count,
    output logic [DEPTH*EW-1:0] sorted
);

    typedef enum logic {LOAD, DRAIN} state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [KEY_W-1:0] key_q [DEPTH];
    logic [KEY_W-1:0] key_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [DEPTH-1:0] beyond;
    logic             accept;

    assign in_ready  = (state_q == LOAD) && (count_q < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DRAIN);
    assign out_key   = out_valid ? key_q[0] : '0;
    assign out_tag   = out_valid ? tag_q[0] : '0;
    assign out_last  = out_valid && (count_q == ONE_C);
    assign count     = count_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_sorted
        assign sorted[g*EW +: EW] = {key_q[g], tag_q[g]};
    end

    // Equal keys are never "beyond", so a new entry lands after its equals.
    always_comb begin
        beyond = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (DESCEND != 0) beyond[i] = key_q[i] < in_key;
                else              beyond[i] = key_q[i] > in_key;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            key_d[i] = key_q[i];
            tag_d[i] = tag_q[i];
        end
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (beyond[0] || count_q == '0) begin
                        key_d[0] = in_key;
                        tag_d[0] = in_tag;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        if (beyond[i-1]) begin
                            key_d[i] = key_q[i-1];
                            tag_d[i] = tag_q[i-1];
                        end else if (beyond[i] || CW'(i) == count_q) begin
                            key_d[i] = in_key;
                            tag_d[i] = in_tag;
                        end
                    end
                    count_d = count_q + ONE_C;
                    if (in_last || count_q == DEPTH_C - ONE_C) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    // Unoccupied slots hold zero, so a plain shift clears the tail.
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        key_d[i] = key_q[i+1];
                        tag_d[i] = tag_q[i+1];
                    end
                    key_d[DEPTH-1] = '0;
                    tag_d[DEPTH-1] = '0;
                    count_d = count_q - ONE_C;
                    if (count_q == ONE_C) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= key_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sort_array_p.sv
// Directed bench for sort_array_p: default ascending 32-slot instance plus an
// 8-slot descending instance sharing clock and reset.
module tb_sort_array_p;

    localparam int EW = 29;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 0, in_last = 0, out_ready = 0;
    logic [23:0]   in_key = '0;
    logic [4:0]    in_tag = '0;
    logic          in_ready, out_valid, out_last;
    logic [23:0]   out_key;
    logic [4:0]    out_tag;
    logic [5:0]    count;
    logic [32*EW-1:0] sorted;

    logic          d_in_valid = 0, d_in_last = 0, d_out_ready = 0;
    logic [23:0]   d_in_key = '0;
    logic [4:0]    d_in_tag = '0;
    logic          d_in_ready, d_out_valid, d_out_last;
    logic [23:0]   d_out_key;
    logic [4:0]    d_out_tag;
    logic [3:0]    d_count;
    logic [8*EW-1:0] d_sorted;

    sort_array_p dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_tag(in_tag), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
        .out_tag(out_tag), .out_last(out_last),
        .count(count), .sorted(sorted)
    );

    sort_array_p #(.DEPTH(8), .DESCEND(1)) dut_d (
        .clk(clk), .reset(reset),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_key(d_in_key),
        .in_tag(d_in_tag), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_key(d_out_key),
        .out_tag(d_out_tag), .out_last(d_out_last),
        .count(d_count), .sorted(d_sorted)
    );

    int tests = 0;
    int fails = 0;

    logic [23:0] rk [64];
    logic [4:0]  rt [64];
    logic        rl [64];
    int          n_out;
    logic        rdy_after;

    task automatic push(input bit sel, input logic [23:0] k, input logic [4:0] t, input bit last);
        @(negedge clk);
        if (sel) begin
            d_in_valid = 1; d_in_key = k; d_in_tag = t; d_in_last = last;
        end else begin
            in_valid = 1; in_key = k; in_tag = t; in_last = last;
        end
        @(negedge clk);
        in_valid = 0; in_last = 0; d_in_valid = 0; d_in_last = 0;
    endtask

    // Holds out_ready high and records every presented entry until out_valid drops.
    task automatic drain(input bit sel);
        bit done = 0;
        n_out = 0;
        if (sel) d_out_ready = 1; else out_ready = 1;
        for (int c = 0; c < 100 && !done; c++) begin
            if (!(sel ? d_out_valid : out_valid)) begin
                done = 1;
            end else begin
                rk[n_out] = sel ? d_out_key : out_key;
                rt[n_out] = sel ? d_out_tag : out_tag;
                rl[n_out] = sel ? d_out_last : out_last;
                n_out++;
                @(negedge clk);
            end
        end
        rdy_after = sel ? d_in_ready : in_ready;
        out_ready = 0; d_out_ready = 0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain_timeout: out_valid still %0b after 100 cycles, required 0", 1'b1);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (count !== 6'd0 || out_valid !== 1'b0 || out_key !== '0 || out_tag !== '0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: count=%0d ov=%0b key=%0d tag=%0d last=%0b, required all 0",
                     count, out_valid, out_key, out_tag, out_last);
        end
        tests++;
        if (sorted !== '0 || d_sorted !== '0) begin
            fails++;
            $display("FAIL reset_sorted: sorted nonzero, required 0");
        end
        tests++;
        if (in_ready !== 1'b1 || d_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: %0b/%0b, required 1/1", in_ready, d_in_ready);
        end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_basic();
        logic [32*EW-1:0] exp;
        logic [23:0] ek [4];
        exp = '0;
        exp[0*EW +: EW] = {24'd0, 5'd3};
        exp[1*EW +: EW] = {24'd2, 5'd0};
        exp[2*EW +: EW] = {24'd3, 5'd2};
        exp[3*EW +: EW] = {24'd16, 5'd1};
        ek = '{24'd0, 24'd2, 24'd3, 24'd16};
        push(0, 24'd2, 5'd0, 0);
        tests++;
        if (count !== 6'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_first: count=%0d in_ready=%0b ov=%0b, required 1/1/0", count, in_ready, out_valid);
        end
        push(0, 24'd16, 5'd1, 0);
        push(0, 24'd3, 5'd2, 0);
        push(0, 24'd0, 5'd3, 1);
        tests++;
        if (sorted !== exp) begin
            fails++;
            $display("FAIL basic_sorted: got %h, required %h", sorted[4*EW-1:0], exp[4*EW-1:0]);
        end
        tests++;
        if (count !== 6'd4 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain_entry: count=%0d ov=%0b in_ready=%0b, required 4/1/0", count, out_valid, in_ready);
        end
        drain(0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rk[i] !== ek[i] || rl[i] !== (i == 3)) begin
                fails++;
                $display("FAIL basic_out[%0d]: key=%0d last=%0b, required %0d/%0b", i, rk[i], rl[i], ek[i], i == 3);
            end
        end
    endtask

    task automatic test_stability();
        push(0, 24'd5, 5'd7, 0);
        push(0, 24'd5, 5'd8, 0);
        push(0, 24'd5, 5'd9, 1);
        drain(0);
        tests++;
        if (n_out !== 3) begin
            fails++;
            $display("FAIL stable_count: drained %0d, required 3", n_out);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rt[i] !== 5'(7 + i) || rl[i] !== (i == 2)) begin
                fails++;
                $display("FAIL stable_out[%0d]: tag=%0d last=%0b, required %0d/%0b", i, rt[i], rl[i], 7 + i, i == 2);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 31; i++) push(0, 24'(31 - i), 5'(i), 0);
        tests++;
        if (in_ready !== 1'b1 || count !== 6'd31) begin
            fails++;
            $display("FAIL full_31: in_ready=%0b count=%0d, required 1/31", in_ready, count);
        end
        push(0, 24'd0, 5'd31, 0);
        tests++;
        if (in_ready !== 1'b0 || count !== 6'd32 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_32: in_ready=%0b count=%0d ov=%0b, required 0/32/1", in_ready, count, out_valid);
        end
        drain(0);
        tests++;
        if (n_out !== 32) begin
            fails++;
            $display("FAIL full_drain_n: drained %0d, required 32", n_out);
        end
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (rk[i] !== 24'(i) || rt[i] !== 5'(31 - i) || rl[i] !== (i == 31)) begin
                fails++;
                $display("FAIL full_out[%0d]: key=%0d tag=%0d last=%0b, required %0d/%0d/%0b",
                         i, rk[i], rt[i], rl[i], i, 31 - i, i == 31);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32*EW-1:0] exp;
        exp = '0;
        exp[0*EW +: EW] = {24'd4, 5'd2};
        exp[1*EW +: EW] = {24'd7, 5'd3};
        exp[2*EW +: EW] = {24'd10, 5'd1};
        push(0, 24'd10, 5'd1, 0);
        push(0, 24'd4, 5'd2, 0);
        push(0, 24'd7, 5'd3, 1);
        in_valid = 1; in_key = 24'd1; in_tag = 5'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (out_key !== 24'd4 || out_tag !== 5'd2 || count !== 6'd3 || sorted !== exp || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: key=%0d tag=%0d count=%0d ov=%0b, required 4/2/3/1",
                         c, out_key, out_tag, count, out_valid);
            end
        end
        in_valid = 0;
        drain(0);
        tests++;
        if (n_out !== 3 || rk[0] !== 24'd4 || rk[1] !== 24'd7 || rk[2] !== 24'd10) begin
            fails++;
            $display("FAIL bp_order: n=%0d keys=%0d,%0d,%0d, required 3 4,7,10", n_out, rk[0], rk[1], rk[2]);
        end
        tests++;
        if (rdy_after !== 1'b1 || count !== 6'd0) begin
            fails++;
            $display("FAIL bp_in_ready: in_ready=%0b count=%0d after last, required 1/0", rdy_after, count);
        end
    endtask

    task automatic test_descend();
        push(1, 24'd1, 5'd0, 0);
        push(1, 24'd9, 5'd1, 0);
        push(1, 24'd4, 5'd2, 1);
        tests++;
        if (d_count !== 4'd3 || d_out_valid !== 1'b1 || d_out_key !== 24'd9) begin
            fails++;
            $display("FAIL desc_head: count=%0d ov=%0b key=%0d, required 3/1/9", d_count, d_out_valid, d_out_key);
        end
        drain(1);
        tests++;
        if (n_out !== 3 || rk[0] !== 24'd9 || rk[1] !== 24'd4 || rk[2] !== 24'd1 || rt[2] !== 5'd0 || rl[2] !== 1'b1) begin
            fails++;
            $display("FAIL desc_order: n=%0d keys=%0d,%0d,%0d, required 3 9,4,1", n_out, rk[0], rk[1], rk[2]);
        end
    endtask

    task automatic test_async_reset();
        logic [32*EW-1:0] exp;
        push(0, 24'd6, 5'd0, 0);
        push(0, 24'd2, 5'd1, 0);
        push(0, 24'd8, 5'd2, 1);
        tests++;
        if (count !== 6'd3 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: count=%0d ov=%0b, required 3/1", count, out_valid);
        end
        #1 reset = 0;
        #1;
        tests++;
        if (count !== 6'd0 || out_valid !== 1'b0 || sorted !== '0 || out_key !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL areset_async: count=%0d ov=%0b key=%0d in_ready=%0b, required 0/0/0/1",
                     count, out_valid, out_key, in_ready);
        end
        #1 reset = 1;
        exp = '0;
        exp[0*EW +: EW] = {24'd1, 5'd1};
        exp[1*EW +: EW] = {24'd5, 5'd0};
        push(0, 24'd5, 5'd0, 0);
        push(0, 24'd1, 5'd1, 1);
        tests++;
        if (sorted !== exp || count !== 6'd2) begin
            fails++;
            $display("FAIL areset_fresh: sorted=%h count=%0d, required %h/2", sorted[2*EW-1:0], count, exp[2*EW-1:0]);
        end
        drain(0);
        tests++;
        if (n_out !== 2 || rk[0] !== 24'd1 || rk[1] !== 24'd5) begin
            fails++;
            $display("FAIL areset_drain: n=%0d keys=%0d,%0d, required 2 1,5", n_out, rk[0], rk[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stability();
        test_full();
        test_backpressure();
        test_descend();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sort_array_p.md
SORT_ARRAY_P -- requirements
Module: sort_array_p

Interface
REQ-001 Parameter DEPTH, default 32: number of sort slots, 2..64.
REQ-002 Parameter KEY_W, default 24: sort key width, in bits.
REQ-003 Parameter TAG_W, default 5: payload tag (original index) width, in bits.
REQ-004 Parameter DESCEND, default 0: 0 places the smallest key in slot 0; 1 places the largest key in slot 0.
REQ-005 Local CW = $clog2(DEPTH+1); EW = KEY_W+TAG_W.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-008 in_valid  in  1  input entry offered.
REQ-009 in_ready  out  1  block can accept an entry this cycle.
REQ-010 in_key  in  KEY_W  sort key.
REQ-011 in_tag  in  TAG_W  payload carried with the key.
REQ-012 in_last  in  1  final entry of the current frame.
REQ-013 out_valid  out  1  slot-0 entry presented for drain.
REQ-014 out_ready  in  1  consumer accepts the out entry.
REQ-015 out_key  out  KEY_W  key of slot 0.
REQ-016 out_tag  out  TAG_W  tag of slot 0.
REQ-017 out_last  out  1  presented entry is the last one of the frame.
REQ-018 count  out  CW  number of occupied slots.
REQ-019 sorted  out  DEPTH*EW  parallel view; slot i occupies bits [i*EW +: EW] as {key,tag}; unoccupied slots read 0.

Function
REQ-020 Two states SHALL exist: LOAD and DRAIN; the state after reset is LOAD.
REQ-021 in_ready SHALL equal (state==LOAD) && (count<DEPTH); an accept occurs on in_valid && in_ready.
REQ-022 An accepted entry SHALL be inserted in the same cycle: every occupied slot whose key is strictly beyond in_key in sort order shifts down one slot, and the new entry fills the vacated position; count increments by 1.
REQ-023 Equal keys SHALL be ordered stably: a new entry goes after all existing entries with the same key.
REQ-024 Key comparison SHALL be unsigned over the full KEY_W bits; the tag never affects ordering.
REQ-025 LOAD->DRAIN SHALL occur on the edge that accepts an entry with in_last=1, or that makes count==DEPTH.
REQ-026 In DRAIN, out_valid=1 and out_key/out_tag SHALL show slot 0; out_last = (count==1).
REQ-027 On out_valid && out_ready, all slots SHALL shift up by one, the last occupied slot clears to 0, and count decrements.
REQ-028 The handshake that drains the out_last entry SHALL return the block to LOAD with count=0; in_ready rises the next cycle.
REQ-029 out_key/out_tag/out_last SHALL be 0 whenever out_valid=0.
REQ-030 in_valid in DRAIN SHALL be ignored, with no state change.
REQ-031 out_ready in LOAD SHALL be ignored.
REQ-032 The outputs sorted, count and out_* SHALL be registered, or decoded from registers only, with no combinational path from in_* to any output.

Reset
REQ-033 While reset=0, every slot SHALL be 0, count=0 and state=LOAD; out_valid=0, out_key=0, out_tag=0, out_last=0, sorted=0, in_ready=1.
REQ-034 Reset asserted mid-LOAD or mid-DRAIN SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-035 Defaults; load keys 2,16,3,0 (tags 0..3), in_last on tag 3 -> sorted slots = keys 0,2,3,16 with tags 3,0,2,1; count=4; state enters DRAIN.
REQ-036 Stability: keys 5,5,5 with tags 7,8,9 -> drained tag order 7,8,9; out_last=1 only on tag 9.
REQ-037 Full: 32 entries with descending keys 31..0 and no in_last -> in_ready=0 once count=32; DRAIN starts; drained keys run 0..31.
REQ-038 Backpressure: out_ready held 0 for 5 cycles in DRAIN -> outputs stable and count unchanged; then out_ready=1 -> one entry per cycle, then in_ready=1 one cycle after out_last.
REQ-039 DESCEND=1, DEPTH=8: keys 1,9,4 -> out order 9,4,1.
REQ-040 Reset pulsed low during DRAIN with count=3 -> count=0, out_valid=0 and sorted=0 asynchronously; a fresh frame then loads correctly.
